sequential_down_counter: RTL and testbench

//  Loadable down-counter with terminal-count (TC) signalling and completion handshake.

---
 rtl/sequential_down_counter_pkg.sv | 12 +
 rtl/sequential_down_counter.sv | 79 +++++++
 tb/tb_sequential_down_counter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sequential_down_counter_pkg.sv
// sequential_down_counter_pkg: shared state encoding and width default for the down-counter.
package sequential_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/sequential_down_counter.sv
// sequential_down_counter: loadable down-counter with terminal-count pulse,
// optional auto-reload and a done/ack completion handshake.
module sequential_down_counter
    import sequential_down_counter_pkg::*;
#(
    parameter int n = DEFAULT_WIDTH
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_load_valid,
    output logic         o_load_ready,
    input  logic [n-1:0] i_load_value,
    input  logic         i_auto_reload,
    input  logic         i_enable,
    input  logic         i_abort,
    input  logic         i_done_ack,
    output logic [n-1:0] o_out,
    output logic         o_busy,
    output logic         o_tc,
    output logic         o_done
);

    state_t       r_state;
    logic [n-1:0] r_out;
    logic [n-1:0] r_reload;
    logic         r_tc;
    logic         w_terminal;

    assign w_terminal = i_enable && (r_out == n'(1));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_out    <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load_valid) begin
                        r_out    <= i_load_value;
                        r_reload <= i_load_value;
                        // A zero load completes immediately and never reloads.
                        r_state  <= (i_load_value == '0) ? ST_DONE : ST_RUN;
                        r_tc     <= (i_load_value == '0);
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        r_out   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_terminal) begin
                        r_tc    <= 1'b1;
                        r_out   <= i_auto_reload ? r_reload : '0;
                        r_state <= i_auto_reload ? ST_RUN : ST_DONE;
                    end else if (i_enable) begin
                        r_out <= r_out - n'(1);
                    end
                end
                ST_DONE: begin
                    if (i_done_ack || i_abort)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= '0;
                end
            endcase
        end
    end

    assign o_out        = r_out;
    assign o_tc         = r_tc;
    assign o_busy       = (r_state == ST_RUN);
    assign o_done       = (r_state == ST_DONE);
    assign o_load_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_sequential_down_counter.sv
// tb_sequential_down_counter: directed table plus hand sequences for reset, max load and ignored loads.
module tb_sequential_down_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load_valid, auto_reload, enable, abort, done_ack;
    logic [3:0] load_value;
    logic       load_ready, busy, tc, done;
    logic [3:0] out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       lv;
        logic [3:0] val;
        logic       ar, en, ab, ack;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    sequential_down_counter #(.n(4)) dut (
        .i_clock      (clk),
        .i_reset_n    (reset_n),
        .i_load_valid (load_valid),
        .o_load_ready (load_ready),
        .i_load_value (load_value),
        .i_auto_reload(auto_reload),
        .i_enable     (enable),
        .i_abort      (abort),
        .i_done_ack   (done_ack),
        .o_out        (out),
        .o_busy       (busy),
        .o_tc         (tc),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic lv, logic [3:0] val, logic ar, logic en, logic ab, logic ack,
                                logic [3:0] o, logic t, logic b, logic d, logic r);
        vec_t v;
        v.lv = lv; v.val = val; v.ar = ar; v.en = en; v.ab = ab; v.ack = ack;
        v.exp = {o, t, b, d, r};
        return v;
    endfunction

    function automatic logic [7:0] obs();
        return {out, tc, busy, done, load_ready};
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got out=%0d tc=%b busy=%b done=%b ready=%b, want out=%0d tc=%b busy=%b done=%b ready=%b",
                     name, act[7:4], act[3], act[2], act[1], act[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(logic lv, logic [3:0] val, logic ar, logic en, logic ab, logic ack);
        load_valid = lv; load_value = val; auto_reload = ar; enable = en; abort = ab; done_ack = ack;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        check("reset_state", obs(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;

        //           lv val ar en ab ack   out tc busy done rdy
        // single shot of 3, then done_ack
        tbl.push_back(mk(1, 3, 0, 1, 0, 0,  3, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
        // gated count: load 4, enable 1,0,0,1,1,0,1
        tbl.push_back(mk(1, 4, 0, 0, 0, 0,  4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  3, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  3, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  3, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
        // auto-reload of 2, then abort
        tbl.push_back(mk(1, 2, 1, 1, 0, 0,  2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  2, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 1));
        // load 9, abort at 6, abort in idle, zero load
        tbl.push_back(mk(1, 9, 0, 1, 0, 0,  9, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  8, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  7, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  6, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 0, 0,  0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1));
        // load in the done_ack cycle is refused
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 1,  0, 0, 0, 0, 1));
        // load of 1, ignored load in RUN, terminal step
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 7, 0, 0, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
        // V=1 with auto-reload: tc every cycle until auto_reload drops
        tbl.push_back(mk(1, 1, 1, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].lv, tbl[i].val, tbl[i].ar, tbl[i].en, tbl[i].ab, tbl[i].ack);
            step();
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // max load 15 with a stray load pulse mid-run
        drive(1, 15, 0, 1, 0, 0);
        step();
        check("max_load", obs(), {4'd15, 1'b0, 1'b1, 1'b0, 1'b0});
        for (int k = 1; k <= 15; k++) begin
            drive(k == 5, 3, 0, 1, 0, 0);
            step();
            check($sformatf("max_step%0d", k), obs(),
                  (k == 15) ? {4'd0, 1'b1, 1'b0, 1'b1, 1'b0}
                            : {4'(15 - k), 1'b0, 1'b1, 1'b0, 1'b0});
        end
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("max_ack", obs(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});

        // asynchronous reset in the middle of a run at out=5
        drive(1, 5, 0, 0, 0, 0);
        step();
        check("pre_reset", obs(), {4'd5, 1'b0, 1'b1, 1'b0, 1'b0});
        drive(0, 0, 0, 1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", obs(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 1, 0, 0);
        step();
        check("post_reset_idle", obs(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
